// File: rtl/pci32_irq_ctrl.sv
`default_nettype none
// pci32_irq_ctrl: synchronises, latches, masks and priority-encodes 32 IRQ lines and
// hands one vector at a time to the CPU through an assert/acknowledge/EOI handshake.
module pci32_irq_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [4:0] SPUR_VEC    = 5'd31
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] irq_i,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [2:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        irq_o,
    output logic [4:0]  vec_o,
    input  logic        iack_i
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ASSERT = 1'b1;

    logic [SYNC_STAGES-1:0][31:0] sync_q;
    logic [31:0] s, s_prev, rise;
    logic [31:0] pend, ena, edge_mode, insv;
    logic [31:0] bmask, w1c, pend_base, ack_clr, eoi_clr, elig, vec_word;
    logic        wr_en, rd_en;
    logic        state, state_nxt;
    logic [4:0]  cand;
    logic        cand_vld, blocked, deliverable, withdraw;
    logic        deliver, ack;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~s_prev;
    assign wr_en = cs_i & we_i;
    assign rd_en = cs_i & ~we_i;
    assign bmask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign w1c   = (wr_en && adr_i == 3'd0) ? (dat_i & bmask) : 32'd0;

    // Edge lines accumulate rises (a rise beats a same-cycle W1C); level lines follow s.
    assign pend_base = (edge_mode & ((pend & ~w1c) | rise)) | (~edge_mode & s);
    assign ack_clr   = ack ? ((32'd1 << vec_o) & edge_mode & ~rise) : 32'd0;
    assign eoi_clr   = (wr_en && adr_i == 3'd5 && sel_i[0]) ? (32'd1 << dat_i[4:0]) : 32'd0;
    assign elig      = pend & ena;

    always_comb begin
        cand     = 5'd0;
        cand_vld = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (elig[i]) begin
                cand     = 5'(i);
                cand_vld = 1'b1;
            end
        end
    end

    // Any in-service line of equal or higher priority blocks the candidate.
    always_comb begin
        blocked = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (insv[i] && 5'(i) <= cand) blocked = 1'b1;
        end
    end

    assign deliverable = cand_vld & ~blocked;
    // Look at next-cycle PEND so a dropped level line withdraws without an extra clock.
    assign withdraw    = ~(pend_base[vec_o] & ena[vec_o]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (deliverable) state_nxt = ST_ASSERT;
            ST_ASSERT: if (iack_i || withdraw) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        deliver = (state == ST_IDLE) && deliverable;
        ack     = (state == ST_ASSERT) && iack_i;
        irq_o   = (state == ST_ASSERT);
    end

    assign vec_word = irq_o ? {1'b1, 26'd0, vec_o} : {1'b0, 26'd0, SPUR_VEC};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            s_prev    <= 32'd0;
            pend      <= 32'd0;
            ena       <= 32'd0;
            edge_mode <= 32'd0;
            insv      <= 32'd0;
            vec_o     <= 5'd0;
            dat_o     <= 32'd0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            s_prev <= s;
            pend   <= pend_base & ~ack_clr;
            insv   <= (insv | (ack ? (32'd1 << vec_o) : 32'd0)) & ~eoi_clr;
            if (deliver) vec_o <= cand;
            if (wr_en && adr_i == 3'd1) ena       <= (ena & ~bmask) | (dat_i & bmask);
            if (wr_en && adr_i == 3'd2) edge_mode <= (edge_mode & ~bmask) | (dat_i & bmask);
            if (rd_en) begin
                case (adr_i)
                    3'd0:    dat_o <= pend;
                    3'd1:    dat_o <= ena;
                    3'd2:    dat_o <= edge_mode;
                    3'd3:    dat_o <= insv;
                    3'd4:    dat_o <= vec_word;
                    default: dat_o <= 32'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pci32_irq_ctrl.sv
`default_nettype none
// tb_pci32_irq_ctrl: directed and randomized scenarios; reads and deliveries are
// predicted into queues and compared by independent monitors.
module tb_pci32_irq_ctrl;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq = 32'd0;
    logic        cs = 1'b0, we = 1'b0, iack = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [2:0]  adr = 3'd0;
    logic [31:0] dat = 32'd0;
    logic [31:0] dat_o;
    logic        irq_o;
    logic [4:0]  vec_o;

    pci32_irq_ctrl #(.SYNC_STAGES(SYNC_STAGES), .SPUR_VEC(5'd31)) dut (
        .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .cs_i(cs), .we_i(we),
        .sel_i(sel), .adr_i(adr), .dat_i(dat), .dat_o(dat_o),
        .irq_o(irq_o), .vec_o(vec_o), .iack_i(iack)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    logic [31:0] rd_q[$];
    int          rd_a[$];
    int          dv_q[$];
    int          dc_q[$];
    logic        rd_seen = 1'b0;
    logic        irq_prev = 1'b0;
    logic [31:0] mon_e;
    int          mon_a, mon_v, mon_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= cs & ~we;
    end

    // Monitor: read data and interrupt deliveries against the predicted queues.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) chk("unexpected read", {31'd0, rd_seen}, 32'd0);
            else begin
                mon_e = rd_q.pop_front();
                mon_a = rd_a.pop_front();
                chk($sformatf("read adr %0d", mon_a), dat_o, mon_e);
            end
        end
        if (irq_o && !irq_prev) begin
            if (dv_q.size() == 0) chk("unexpected irq_o", {31'd0, irq_o}, 32'd0);
            else begin
                mon_v = dv_q.pop_front();
                mon_c = dc_q.pop_front();
                chk("irq vec", {27'd0, vec_o}, mon_v);
                chk("irq cycle", cyc, mon_c);
            end
        end
        irq_prev = irq_o;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; adr = a; sel = s; dat = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; sel = 4'd0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        rd_a.push_back(int'(a));
        cs = 1'b1; we = 1'b0; adr = a;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic pulse_iack();
        iack = 1'b1;
        @(negedge clk);
        iack = 1'b0;
    endtask

    task automatic expect_irq(input int v, input int dly);
        dv_q.push_back(v);
        dc_q.push_back(cyc + dly);
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!irq_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!irq_o) begin
            chk(name, {31'd0, irq_o}, 32'd1);
            dv_q.delete();
            dc_q.delete();
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction-level model: pending set, enables, edge set and in-service set.
    task automatic rand_trial();
        logic [31:0] pat, em, en, pm, im, e;
        int c;
        pat = $urandom; em = $urandom; en = $urandom;
        im  = 32'd0;
        irq = 32'd0;
        idle(6);
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd0, 4'hF, 32'hFFFF_FFFF);
        wr(3'd2, 4'hF, em);
        irq = pat;
        idle(6);
        pm = pat;
        rd(3'd0, pm);
        e = pm & en;
        if (e != 0) expect_irq(lowest(e), 2);
        wr(3'd1, 4'hF, en);
        while (e != 0) begin
            c = lowest(e);
            wait_irq("rand irq timeout");
            rd(3'd4, 32'h8000_0000 | 32'(c));
            pulse_iack();
            im[c] = 1'b1;
            if (em[c]) pm[c] = 1'b0;
            rd(3'd3, im);
            rd(3'd0, pm);
            if (!em[c]) begin
                irq[c] = 1'b0;
                idle(6);
                pm[c] = 1'b0;
            end
            im[c] = 1'b0;
            e = pm & en;
            if (e != 0) expect_irq(lowest(e), 2);
            wr(3'd5, 4'h1, 32'(c));
        end
        rd(3'd4, 32'h0000_001F);
        rd(3'd3, 32'd0);
        irq = 32'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        chk("reset irq_o", {31'd0, irq_o}, 32'd0);
        chk("reset vec_o", {27'd0, vec_o}, 32'd0);
        chk("reset dat_o", dat_o, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Reset in the middle of a handshake with one line already in service.
        wr(3'd1, 4'hF, 32'h0000_0050);
        wr(3'd2, 4'hF, 32'h8000_0000);
        expect_irq(6, SYNC_STAGES + 2);
        irq[6] = 1'b1;
        wait_irq("t1 irq6 timeout");
        pulse_iack();
        expect_irq(4, SYNC_STAGES + 2);
        irq[4] = 1'b1;
        wait_irq("t1 irq4 timeout");
        rst_n = 1'b0;
        #1;
        chk("t1 irq_o in reset", {31'd0, irq_o}, 32'd0);
        chk("t1 vec_o in reset", {27'd0, vec_o}, 32'd0);
        @(negedge clk);
        irq = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        for (int a = 0; a < 4; a++) rd(3'(a), 32'd0);
        rd(3'd4, 32'h0000_001F);

        // Edge line 5 with a one-clock pulse.
        wr(3'd2, 4'hF, 32'h0000_0020);
        wr(3'd1, 4'hF, 32'h0000_0020);
        expect_irq(5, SYNC_STAGES + 2);
        irq[5] = 1'b1;
        @(negedge clk);
        irq[5] = 1'b0;
        wait_irq("t2 irq timeout");
        pulse_iack();
        rd(3'd3, 32'h0000_0020);
        rd(3'd0, 32'd0);
        wr(3'd5, 4'h1, 32'd5);
        rd(3'd3, 32'd0);

        // Priority: level lines 3 and 7; 7 waits for EOI of 3.
        wr(3'd2, 4'hF, 32'd0);
        wr(3'd1, 4'hF, 32'h0000_00FF);
        expect_irq(3, SYNC_STAGES + 2);
        irq[7] = 1'b1;
        irq[3] = 1'b1;
        wait_irq("t3 irq3 timeout");
        pulse_iack();
        rd(3'd3, 32'h0000_0008);
        irq[3] = 1'b0;
        idle(10);
        rd(3'd4, 32'h0000_001F);
        expect_irq(7, 2);
        wr(3'd5, 4'h1, 32'd3);
        wait_irq("t3 irq7 timeout");
        pulse_iack();
        irq[7] = 1'b0;
        idle(6);
        wr(3'd5, 4'h1, 32'd7);
        rd(3'd3, 32'd0);

        // Withdraw: level line 9 drops before acknowledge.
        wr(3'd1, 4'hF, 32'h0000_0200);
        expect_irq(9, SYNC_STAGES + 2);
        irq[9] = 1'b1;
        wait_irq("t4 irq timeout");
        irq[9] = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        chk("t4 withdraw irq_o", {31'd0, irq_o}, 32'd0);
        rd(3'd3, 32'd0);

        // Edge rise in the same cycle as a W1C of that bit: the rise wins.
        wr(3'd1, 4'hF, 32'd0);
        wr(3'd2, 4'hF, 32'h0000_0004);
        irq[2] = 1'b1;
        idle(2);
        wr(3'd0, 4'hF, 32'h0000_0004);
        rd(3'd0, 32'h0000_0004);
        wr(3'd0, 4'hF, 32'h0000_0004);
        rd(3'd0, 32'd0);
        irq[2] = 1'b0;
        idle(4);

        // Byte-laned ENA, spurious vector, unused addresses.
        wr(3'd1, 4'h1, 32'hFFFF_FFFF);
        rd(3'd1, 32'h0000_00FF);
        rd(3'd4, 32'h0000_001F);
        pulse_iack();
        rd(3'd4, 32'h0000_001F);
        wr(3'd6, 4'hF, 32'hFFFF_FFFF);
        rd(3'd6, 32'd0);
        rd(3'd7, 32'd0);

        for (int t = 0; t < 8; t++) rand_trial();

        idle(6);
        chk("read queue drained", rd_q.size(), 32'd0);
        chk("irq queue drained", dv_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
